prefetch_buffer: RTL and testbench
==================================

Name: prefetch_buffer

Overview:
- Consumer end of the ISB prefetcher's prefetch_v/prefetch_addr output.
- Accepts prefetch addresses, filters duplicates, and issues one memory read at a time.
- Holds returned data in a small fully-associative buffer.
- Answers demand lookups from the core; a hit consumes the entry.

Parameters:
- ENTRIES, 4, number of buffer entries; power of 2, minimum 2.
- AW, 16, address width; matches the prefetcher's prefetch_addr.
- DW, 16, data width of memory responses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- pf_v  in  1  prefetch request valid (from the prefetcher's prefetch_v).
- pf_addr  in  AW  prefetch address (from the prefetcher's prefetch_addr).
- pf_dup  out  1  one-cycle pulse: request matched an existing entry and was ignored.
- pf_drop  out  1  one-cycle pulse: request dropped because its victim was in flight.
- mem_req_v  out  1  memory read request valid.
- mem_req_addr  out  AW  memory read address.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_v  in  1  read data valid; at most one response per accepted request, in order.
- mem_resp_data  in  DW  read data.
- lk_v  in  1  demand lookup valid.
- lk_addr  in  AW  demand lookup address.
- lk_hit  out  1  lookup hit; registered, valid the cycle after lk_v.
- lk_data  out  DW  hit data; valid when lk_hit=1, 0 otherwise.

Behaviour:
- Entry state: INVALID, QUEUED, ISSUED, FILLED; each entry also holds addr[AW] and data[DW].
- All same-cycle decisions (dup check, victim check, issue select, lookup match) use pre-edge state.
- Reset: all entries INVALID, alloc_ptr=0, FSM=IDLE. All outputs are 0 at reset and in the cycle after reset.
- Allocation, pf_v=1:
  - If pf_addr equals the addr of any non-INVALID entry: pf_dup=1 next cycle, no state change.
  - Else the victim is entry[alloc_ptr]. If the victim is in flight (ISSUED, or the current REQ target): pf_drop=1 next cycle, alloc_ptr unchanged.
  - Else the victim becomes QUEUED with the new addr; any old QUEUED or FILLED content is overwritten silently. alloc_ptr <= (alloc_ptr+1) mod ENTRIES, wrapping naturally.
- Issue FSM:
  - IDLE: if any entry is QUEUED, latch the lowest-index QUEUED entry as tgt, mem_req_addr<=addr, go to REQ. Otherwise stay.
  - REQ: mem_req_v=1; mem_req_addr held stable until handshake. On mem_req_ready=1: entry[tgt] becomes ISSUED, mem_req_v drops next cycle, go to WAIT.
  - WAIT: on mem_resp_v=1: entry[tgt].data<=mem_resp_data, state becomes FILLED, go to IDLE.
  - mem_resp_v outside WAIT is ignored. This covers a stray response after a mid-WAIT reset.
- Latency:
  - pf_v at cycle N: entry QUEUED at N+1; mem_req_v earliest at N+2 (IDLE and empty at N+1).
  - Response at cycle M: entry FILLED at M+1; a lookup at M+1 hits with lk_hit at M+2.
- Lookup, lk_v=1:
  - Hits only a FILLED entry with addr==lk_addr. On hit: lk_hit=1 and lk_data=data next cycle; entry becomes INVALID (consumed).
  - A QUEUED or ISSUED match is a miss with no state change.
  - Without lk_v, lk_hit=0 and lk_data=0.
- Simultaneous events:
  - Lookup hit and pf of the same addr in one cycle: pf reports pf_dup; the entry is still consumed.
  - Response and lookup of the same addr in one cycle: the lookup misses; the entry becomes FILLED.
  - Allocation overwriting the entry the IDLE state selects this cycle: the allocation wins, and tgt/mem_req_addr take the new addr.
  - pf_dup and pf_drop are never both 1.
- Reset mid-operation (REQ or WAIT): immediate return to IDLE, all entries INVALID, mem_req_v=0 next cycle.

Decomposition:
- Shared header isb_defs.vh: entry state encodings (INVALID=0, QUEUED=1, ISSUED=2, FILLED=3), FSM state encodings (IDLE, REQ, WAIT), AW/DW defaults shared with the prefetcher.
- One sub-module, pfb_issue_fsm: owns the IDLE/REQ/WAIT FSM, tgt, and mem_req_* signals.
  - Inputs: QUEUED bitmask, addr array.
  - Outputs: issue/fill strobes and tgt index.
- The parent holds the entry array, dedup, allocation and lookup logic.

Test Plan:
- Reset, then pf 0x1234 with mem_req_ready=1 and a response 0xBEEF 3 cycles later: mem_req_v at N+2 with addr 0x1234. Lookup 0x1234 after the fill gives lk_hit=1, lk_data=0xBEEF. A repeat lookup misses.
- pf 0x0010 twice on consecutive cycles: second gives pf_dup=1; exactly one memory request issued.
- Hold mem_req_ready=0 for 5 cycles: mem_req_v=1 and addr constant throughout. Lookup of that addr misses.
- pf 0x1..0x5 with memory stalled in WAIT on entry 0: the 5th request wraps to entry 0, gets pf_drop=1, and alloc_ptr stays 0.
- Assert rst during WAIT, then drive mem_resp_v=1: it is ignored, all lookups miss, and outputs are 0.
- Response 0x00AA for 0x0040 in the same cycle as lookup 0x0040: lk_hit=0. Lookup next cycle: lk_hit=1, lk_data=0x00AA.

Source files
------------

// File: rtl/prefetch_buffer_pkg.sv
// Shared encodings and width defaults for the prefetch buffer and its issue FSM.
// Entry and FSM encodings match the values the ISB prefetcher side expects.
package prefetch_buffer_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_QUEUED  = 2'd1,
    ST_ISSUED  = 2'd2,
    ST_FILLED  = 2'd3
  } entry_state_t;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REQ  = 2'd1,
    FSM_WAIT = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/prefetch_buffer_if.sv
// Prefetch, memory and lookup signals of the prefetch buffer, seen from the buffer (slave)
// and from its environment (master).
interface prefetch_buffer_if import prefetch_buffer_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          pf_v;
  logic [AW-1:0] pf_addr;
  logic          pf_dup;
  logic          pf_drop;
  logic          mem_req_v;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_v;
  logic [DW-1:0] mem_resp_data;
  logic          lk_v;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic [DW-1:0] lk_data;

  modport slave (
    input  pf_v, pf_addr, mem_req_ready, mem_resp_v, mem_resp_data, lk_v, lk_addr,
    output pf_dup, pf_drop, mem_req_v, mem_req_addr, lk_hit, lk_data
  );

  modport master (
    output pf_v, pf_addr, mem_req_ready, mem_resp_v, mem_resp_data, lk_v, lk_addr,
    input  pf_dup, pf_drop, mem_req_v, mem_req_addr, lk_hit, lk_data
  );
endinterface

// File: rtl/prefetch_buffer_issue_fsm.sv
// Issues one memory read at a time for the lowest-index QUEUED entry; tgt/req_addr latch in
// IDLE, req held in REQ until mem ready, WAIT absorbs the single in-order response.
module pfb_issue_fsm import prefetch_buffer_pkg::*; #(
  parameter  int ENTRIES = 4,
  parameter  int AW      = AW_DEF,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ENTRIES-1:0] queued,
  input  logic [AW-1:0]     addr [ENTRIES],
  input  logic              req_ready,
  input  logic              resp_v,
  output logic              req_v,
  output logic [AW-1:0]     req_addr,
  output logic              issue,
  output logic              fill,
  output logic              busy,
  output logic [IW-1:0]     tgt
);

  fsm_state_t    state;
  fsm_state_t    state_nxt;
  logic          pick_v;
  logic [IW-1:0] pick;

  always_comb begin
    pick_v = |queued;
    pick   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (queued[i]) pick = IW'(i);
    end
  end

  // addr already carries any allocation landing this cycle, so a same-cycle overwrite wins
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FSM_IDLE;
      tgt      <= '0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == FSM_IDLE && pick_v) begin
        tgt      <= pick;
        req_addr <= addr[pick];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FSM_IDLE: if (pick_v)    state_nxt = FSM_REQ;
      FSM_REQ:  if (req_ready) state_nxt = FSM_WAIT;
      FSM_WAIT: if (resp_v)    state_nxt = FSM_IDLE;
      default:                 state_nxt = FSM_IDLE;
    endcase
  end

  always_comb begin
    req_v = (state == FSM_REQ);
    busy  = (state == FSM_REQ);
    issue = (state == FSM_REQ) && req_ready;
    fill  = (state == FSM_WAIT) && resp_v;
  end

endmodule

// File: rtl/prefetch_buffer.sv
// Fully-associative prefetch buffer: dedups/allocates prefetches, answers lookups one cycle
// later (hit consumes), memory side is one outstanding read with ready backpressure.
module prefetch_buffer import prefetch_buffer_pkg::*; #(
  parameter  int ENTRIES = 4,
  parameter  int AW      = AW_DEF,
  parameter  int DW      = DW_DEF,
  localparam int IW      = $clog2(ENTRIES)
) (
  input logic              clk,
  input logic              rst,
  prefetch_buffer_if.slave bus
);

  entry_state_t   st      [ENTRIES];
  logic [AW-1:0]  addr_q  [ENTRIES];
  logic [DW-1:0]  data_q  [ENTRIES];
  logic [AW-1:0]  addr_fwd[ENTRIES];
  logic [IW-1:0]  alloc_ptr;

  logic [ENTRIES-1:0] queued;
  logic [ENTRIES-1:0] hit;
  logic               dup;
  logic               victim_busy;
  logic               alloc;
  logic               drop;
  logic               hit_any;
  logic [DW-1:0]      hit_data;

  logic               issue;
  logic               fill;
  logic               busy;
  logic [IW-1:0]      tgt;

  always_comb begin
    dup      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      queued[i] = (st[i] == ST_QUEUED);
      hit[i]    = bus.lk_v && (st[i] == ST_FILLED) && (addr_q[i] == bus.lk_addr);
      if (st[i] != ST_INVALID && addr_q[i] == bus.pf_addr) dup = 1'b1;
      if (hit[i]) hit_data = data_q[i];
    end
    hit_any = |hit;
    // the REQ target is still QUEUED but must not be overwritten mid-handshake
    victim_busy = (st[alloc_ptr] == ST_ISSUED) || (busy && tgt == alloc_ptr);
    alloc       = bus.pf_v && !dup && !victim_busy;
    drop        = bus.pf_v && !dup && victim_busy;
    for (int i = 0; i < ENTRIES; i++) begin
      addr_fwd[i] = (alloc && alloc_ptr == IW'(i)) ? bus.pf_addr : addr_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr   <= '0;
      bus.pf_dup  <= 1'b0;
      bus.pf_drop <= 1'b0;
      bus.lk_hit  <= 1'b0;
      bus.lk_data <= '0;
      for (int i = 0; i < ENTRIES; i++) st[i] <= ST_INVALID;
    end else begin
      bus.pf_dup  <= bus.pf_v && dup;
      bus.pf_drop <= drop;
      bus.lk_hit  <= hit_any;
      bus.lk_data <= hit_any ? hit_data : '0;
      // a new allocation outranks consumption of the same slot
      for (int i = 0; i < ENTRIES; i++) begin
        if (fill && tgt == IW'(i))        st[i] <= ST_FILLED;
        if (issue && tgt == IW'(i))       st[i] <= ST_ISSUED;
        if (hit[i])                       st[i] <= ST_INVALID;
        if (alloc && alloc_ptr == IW'(i)) st[i] <= ST_QUEUED;
      end
      if (alloc) alloc_ptr <= alloc_ptr + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      addr_q[i] <= addr_fwd[i];
      if (fill && tgt == IW'(i)) data_q[i] <= bus.mem_resp_data;
    end
  end

  pfb_issue_fsm #(
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_issue (
    .clk       (clk),
    .rst       (rst),
    .queued    (queued),
    .addr      (addr_fwd),
    .req_ready (bus.mem_req_ready),
    .resp_v    (bus.mem_resp_v),
    .req_v     (bus.mem_req_v),
    .req_addr  (bus.mem_req_addr),
    .issue     (issue),
    .fill      (fill),
    .busy      (busy),
    .tgt       (tgt)
  );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs, a monitor
// pops and compares them one cycle later.
module tb_prefetch_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prefetch_buffer_if #(.AW(16), .DW(16)) bus ();

  prefetch_buffer #(.ENTRIES(4), .AW(16), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        chk_addr;
    logic        pf_dup;
    logic        pf_drop;
    logic        lk_hit;
    logic [15:0] lk_data;
    logic        req_v;
    logic [15:0] req_addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: slot contents plus a tiny "memory port" story.
  // kind: 0 empty, 1 wants fetching, 2 being fetched, 3 holds data
  int          m_kind[4];
  logic [15:0] m_addr[4];
  logic [15:0] m_data[4];
  int          m_ptr;
  int          m_phase;   // 0 nothing outstanding, 1 offering request, 2 awaiting data
  int          m_tgt;
  logic [15:0] m_req_addr;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pf_dup",  16'(bus.pf_dup),  16'(e.pf_dup));
        chk("pf_drop", 16'(bus.pf_drop), 16'(e.pf_drop));
        chk("lk_hit",  16'(bus.lk_hit),  16'(e.lk_hit));
        chk("lk_data", bus.lk_data,      e.lk_data);
        chk("mem_req_v", 16'(bus.mem_req_v), 16'(e.req_v));
        if (e.chk_addr) chk("mem_req_addr", bus.mem_req_addr, e.req_addr);
      end
    end
  end

  task automatic step(input bit r, input bit pv, input logic [15:0] pa,
                      input bit lv, input logic [15:0] la,
                      input bit rdy, input bit rv, input logic [15:0] rd);
    exp_t e;
    int   hit;
    int   first;
    int   victim;
    int   nphase;
    bit   dup;
    bit   do_alloc;
    @(negedge clk);
    rst               = r;
    bus.pf_v          = pv;
    bus.pf_addr       = pa;
    bus.lk_v          = lv;
    bus.lk_addr       = la;
    bus.mem_req_ready = rdy;
    bus.mem_resp_v    = rv;
    bus.mem_resp_data = rd;
    e = '0;
    if (r) begin
      for (int i = 0; i < 4; i++) m_kind[i] = 0;
      m_ptr = 0; m_phase = 0; m_tgt = 0; m_req_addr = '0;
      e.chk_addr = 1'b1;
    end else begin
      hit = -1; dup = 0; do_alloc = 0; victim = m_ptr;
      for (int i = 0; i < 4; i++) begin
        if (lv && m_kind[i] == 3 && m_addr[i] == la) hit = i;
        if (pv && m_kind[i] != 0 && m_addr[i] == pa) dup = 1;
      end
      e.pf_dup = dup;
      if (pv && !dup) begin
        if (m_kind[victim] == 2 || (m_phase == 1 && m_tgt == victim)) e.pf_drop = 1'b1;
        else do_alloc = 1;
      end
      if (hit >= 0) begin
        e.lk_hit  = 1'b1;
        e.lk_data = m_data[hit];
      end
      nphase = m_phase;
      if (m_phase == 0) begin
        first = -1;
        for (int i = 3; i >= 0; i--) if (m_kind[i] == 1) first = i;
        if (first >= 0) begin
          m_tgt      = first;
          m_req_addr = (do_alloc && victim == first) ? pa : m_addr[first];
          nphase     = 1;
        end
      end else if (m_phase == 1) begin
        if (rdy) begin m_kind[m_tgt] = 2; nphase = 2; end
      end else if (rv) begin
        m_kind[m_tgt] = 3; m_data[m_tgt] = rd; nphase = 0;
      end
      if (hit >= 0) m_kind[hit] = 0;
      if (do_alloc) begin
        m_kind[victim] = 1;
        m_addr[victim] = pa;
        m_ptr = (m_ptr + 1) % 4;
      end
      m_phase    = nphase;
      e.req_v    = (m_phase == 1);
      e.chk_addr = e.req_v;
    end
    e.req_addr = m_req_addr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit rdy, input bit auto_resp);
    for (int k = 0; k < n; k++)
      step(0, 0, 16'h0, 0, 16'h0, rdy, auto_resp && m_phase == 2, 16'($urandom));
  endtask

  initial begin
    bus.pf_v = 0; bus.pf_addr = '0; bus.lk_v = 0; bus.lk_addr = '0;
    bus.mem_req_ready = 0; bus.mem_resp_v = 0; bus.mem_resp_data = '0;
    for (int i = 0; i < 4; i++) begin m_addr[i] = '0; m_data[i] = '0; end

    // single prefetch, fill 3 cycles later, hit then miss
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 1, 16'h1234, 0, 16'h0, 1, 0, 16'h0);
    idle(2, 1, 0);
    step(0, 0, 16'h0, 0, 16'h0, 1, 1, 16'hBEEF);
    step(0, 0, 16'h0, 1, 16'h1234, 1, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'h1234, 1, 0, 16'h0);

    // back-to-back duplicate
    step(0, 1, 16'h0010, 0, 16'h0, 1, 0, 16'h0);
    step(0, 1, 16'h0010, 0, 16'h0, 1, 0, 16'h0);
    idle(6, 1, 1);

    // stalled request holds address; lookup of it misses
    step(0, 1, 16'h0777, 0, 16'h0, 0, 0, 16'h0);
    idle(3, 0, 0);
    step(0, 0, 16'h0, 1, 16'h0777, 0, 0, 16'h0);
    idle(3, 0, 0);
    idle(4, 1, 1);

    // wrap onto the in-flight slot
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    for (int a = 1; a <= 6; a++) step(0, 1, 16'(a), 0, 16'h0, 1, 0, 16'h0);

    // reset during WAIT, stray response ignored, everything misses
    step(1, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
    step(0, 0, 16'h0, 0, 16'h0, 0, 1, 16'h5555);
    for (int a = 1; a <= 6; a++) step(0, 0, 16'h0, 1, 16'(a), 1, 0, 16'h0);

    // response and lookup of the same address in one cycle
    step(0, 1, 16'h0040, 0, 16'h0, 1, 0, 16'h0);
    idle(2, 1, 0);
    step(0, 0, 16'h0, 1, 16'h0040, 1, 1, 16'h00AA);
    step(0, 0, 16'h0, 1, 16'h0040, 1, 0, 16'h0);

    // random traffic over a small address pool to provoke dups, drops and overwrites
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           m_phase == 2 && $urandom_range(0, 2) == 0, 16'($urandom));
    end
    idle(2, 1, 1);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
